// File: rtl/input_read_arbiter.sv
// Two-requester read arbiter in front of a single-ported input register.
// The core and the timer/counter unit share one read path. Each granted
// read takes three cycles: grant (IDLE), register access (SAMPLE) and
// completion (DONE). Ties go to whichever requester was not served last.
module input_read_arbiter #(
    parameter int INPUT_NUM = 8,
    parameter int ADDR_LEN  = 3
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                core_req,
    input  logic [ADDR_LEN-1:0] core_addr,
    output logic                core_ack,
    output logic                core_data,

    input  logic                per_req,
    input  logic [ADDR_LEN-1:0] per_addr,
    output logic                per_ack,
    output logic                per_data,

    output logic                addr_err,

    output logic                in_read,
    output logic [ADDR_LEN-1:0] in_addr,
    input  logic                in_data,

    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    // Transaction context, frozen at grant time so requester-side changes
    // during SAMPLE/DONE cannot disturb the read in flight.
    logic                winnerPer;
    logic [ADDR_LEN-1:0] latchedAddr;
    logic                capturedBit;

    // Round-robin history: 1 means the peripheral got the previous grant.
    // Resets to peripheral so the core wins the first tie.
    logic                lastServedPer;

    logic anyReq;
    logic grantPer;
    logic addrValid;

    assign anyReq = core_req | per_req;

    // Peripheral wins when it is the only requester, or on a tie when the
    // core was served last.
    assign grantPer = per_req & (~core_req | ~lastServedPer);

    // Out-of-range addresses never touch the input register.
    assign addrValid = (32'(latchedAddr) < 32'(INPUT_NUM));

    // State register; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: fixed three-cycle walk once a grant happens.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = anyReq ? SAMPLE : IDLE;
            SAMPLE:  stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Grant bookkeeping: winner, its address and the round-robin history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winnerPer     <= 1'b0;
            latchedAddr   <= '0;
            lastServedPer <= 1'b1;
        end else if (state == IDLE && anyReq) begin
            winnerPer     <= grantPer;
            lastServedPer <= grantPer;
            latchedAddr   <= grantPer ? per_addr : core_addr;
        end
    end

    // Capture the register bit at the end of SAMPLE. Only a clean 1 counts;
    // 0, x and z from an undriven or glitching source all read as 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            capturedBit <= 1'b0;
        end else if (state == SAMPLE) begin
            capturedBit <= addrValid && (in_data === 1'b1);
        end
    end

    // Output decode straight from registered state, so reset clears every
    // output without waiting for a clock edge.
    always_comb begin
        core_ack  = 1'b0;
        core_data = 1'b0;
        per_ack   = 1'b0;
        per_data  = 1'b0;
        addr_err  = 1'b0;
        in_read   = 1'b0;
        in_addr   = latchedAddr;
        busy      = (state != IDLE);
        case (state)
            SAMPLE: begin
                in_read = addrValid;
            end
            DONE: begin
                addr_err = ~addrValid;
                if (winnerPer) begin
                    per_ack  = 1'b1;
                    per_data = capturedBit;
                end else begin
                    core_ack  = 1'b1;
                    core_data = capturedBit;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_input_read_arbiter.sv
// Directed bench for input_read_arbiter. A default-sized instance covers
// arbitration, latency, data capture and reset; a six-input instance covers
// the out-of-range address path. Outputs are compared as one packed vector
// {busy, in_read, in_addr, core_ack, core_data, per_ack, per_data, addr_err}
// sampled 1 ns after each rising edge.
module tb_input_read_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       coreReq = 1'b0;
    logic [2:0] coreAddr = '0;
    logic       perReq = 1'b0;
    logic [2:0] perAddr = '0;
    logic       coreAck, coreData, perAck, perData, addrErr, inRead, busy;
    logic [2:0] inAddr;
    logic       inData;
    logic [7:0] inBits = '0;
    logic       inZ = 1'b0;

    logic       perReq6 = 1'b0;
    logic [2:0] perAddr6 = '0;
    logic       coreReq6 = 1'b0;
    logic [2:0] coreAddr6 = '0;
    logic       coreAck6, coreData6, perAck6, perData6, addrErr6, inRead6, busy6;
    logic [2:0] inAddr6;
    logic       inData6 = 1'b1;

    int errors = 0;
    int checks = 0;

    // Input register model.
    assign inData = inZ ? 1'bz : inBits[inAddr];

    wire [9:0] obs  = {busy, inRead, inAddr, coreAck, coreData, perAck, perData, addrErr};
    wire [9:0] obs6 = {busy6, inRead6, inAddr6, coreAck6, coreData6, perAck6, perData6, addrErr6};

    always #5 clk = ~clk;

    input_read_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(coreReq), .core_addr(coreAddr), .core_ack(coreAck), .core_data(coreData),
        .per_req(perReq), .per_addr(perAddr), .per_ack(perAck), .per_data(perData),
        .addr_err(addrErr), .in_read(inRead), .in_addr(inAddr), .in_data(inData),
        .busy(busy)
    );

    input_read_arbiter #(.INPUT_NUM(6), .ADDR_LEN(3)) dut6 (
        .clk(clk), .reset(reset),
        .core_req(coreReq6), .core_addr(coreAddr6), .core_ack(coreAck6), .core_data(coreData6),
        .per_req(perReq6), .per_addr(perAddr6), .per_ack(perAck6), .per_data(perData6),
        .addr_err(addrErr6), .in_read(inRead6), .in_addr(inAddr6), .in_data(inData6),
        .busy(busy6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        coreReq = 1'b1;
        perReq  = 1'b1;
        step();
        step();
        exp = '0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs, exp); end
        checks++;
        if (obs6 !== exp) begin errors++; $display("FAIL reset_outputs6: got %b exp %b", obs6, exp); end
        coreReq = 1'b0;
        perReq  = 1'b0;
        reset   = 1'b1;
        step();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL idle_after_reset: got %b exp %b", obs, exp); end
    endtask

    // Core-only read of address 5; address change mid-flight is ignored.
    task automatic test_core_read();
        logic [9:0] exp;
        inBits    = 8'b0010_0000;
        coreReq   = 1'b1;
        coreAddr  = 3'd5;
        step();
        exp = {2'b11, 3'd5, 5'b00000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL core_sample: got %b exp %b", obs, exp); end
        coreAddr = 3'd0;
        step();
        exp = {2'b10, 3'd5, 5'b11000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL core_done: got %b exp %b", obs, exp); end
        coreReq = 1'b0;
        step();
        exp = {2'b00, 3'd5, 5'b00000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL core_idle: got %b exp %b", obs, exp); end
    endtask

    // Tie right after reset: core first, peripheral three cycles later.
    task automatic test_simultaneous();
        logic [9:0] exp [6];
        pulse_reset();
        inBits   = 8'b1000_0000;
        coreReq  = 1'b1; coreAddr = 3'd2;
        perReq   = 1'b1; perAddr  = 3'd7;
        exp[0] = {2'b11, 3'd2, 5'b00000};
        exp[1] = {2'b10, 3'd2, 5'b10000};
        exp[2] = {2'b00, 3'd2, 5'b00000};
        exp[3] = {2'b11, 3'd7, 5'b00000};
        exp[4] = {2'b10, 3'd7, 5'b00110};
        exp[5] = {2'b00, 3'd7, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin errors++; $display("FAIL tie_cycle%0d: got %b exp %b", i, obs, exp[i]); end
            if (i == 1) coreReq = 1'b0;
            if (i == 4) perReq  = 1'b0;
        end
    endtask

    // Both held for 12 cycles: acks alternate core, per, core, per.
    task automatic test_back_to_back();
        logic [9:0] exp;
        logic [2:0] a;
        logic       perWin;
        inBits   = 8'b0000_0010;
        coreReq  = 1'b1; coreAddr = 3'd1;
        perReq   = 1'b1; perAddr  = 3'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            perWin = ((i / 3) % 2) == 1;
            a = perWin ? 3'd3 : 3'd1;
            case (i % 3)
                0:       exp = {2'b11, a, 5'b00000};
                1:       exp = perWin ? {2'b10, a, 5'b00100} : {2'b10, a, 5'b11000};
                default: exp = {2'b00, a, 5'b00000};
            endcase
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL rr_cycle%0d: got %b exp %b", i, obs, exp); end
        end
        coreReq = 1'b0;
        perReq  = 1'b0;
        step();
    endtask

    // Six-input instance: addresses 6 and 7 are out of range.
    task automatic test_addr_err();
        logic [9:0] exp;
        logic [2:0] a;
        logic       ok;
        for (int k = 5; k <= 7; k++) begin
            a  = 3'(k);
            ok = (k < 6);
            perReq6  = 1'b1;
            perAddr6 = a;
            step();
            exp = {1'b1, ok, a, 5'b00000};
            checks++;
            if (obs6 !== exp) begin errors++; $display("FAIL err_sample_a%0d: got %b exp %b", k, obs6, exp); end
            step();
            exp = ok ? {2'b10, a, 5'b00110} : {2'b10, a, 5'b00101};
            checks++;
            if (obs6 !== exp) begin errors++; $display("FAIL err_done_a%0d: got %b exp %b", k, obs6, exp); end
            perReq6 = 1'b0;
            step();
        end
    endtask

    // Floating register bit must read as 0.
    task automatic test_z_data();
        logic [9:0] exp;
        inZ      = 1'b1;
        coreReq  = 1'b1;
        coreAddr = 3'd4;
        step();
        exp = {2'b11, 3'd4, 5'b00000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL z_sample: got %b exp %b", obs, exp); end
        step();
        exp = {2'b10, 3'd4, 5'b10000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL z_done: got %b exp %b", obs, exp); end
        coreReq = 1'b0;
        inZ     = 1'b0;
        step();
    endtask

    // Request dropped right after grant still completes with an ack.
    task automatic test_dropped_req();
        logic [9:0] exp;
        inBits   = 8'b0100_0000;
        coreReq  = 1'b1;
        coreAddr = 3'd6;
        step();
        coreReq = 1'b0;
        step();
        exp = {2'b10, 3'd6, 5'b11000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL drop_done: got %b exp %b", obs, exp); end
        step();
        step();
        exp = {2'b00, 3'd6, 5'b00000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL drop_no_regrant: got %b exp %b", obs, exp); end
    endtask

    // Reset during SAMPLE aborts with no ack; core re-granted on release.
    task automatic test_reset_mid();
        logic [9:0] exp;
        inBits   = 8'b0000_1000;
        coreReq  = 1'b1;
        coreAddr = 3'd3;
        step();
        #2;
        reset = 1'b0;
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL async_abort: got %b exp %b", obs, exp); end
        step();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL abort_no_ack: got %b exp %b", obs, exp); end
        reset = 1'b1;
        step();
        exp = {2'b11, 3'd3, 5'b00000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL regrant_sample: got %b exp %b", obs, exp); end
        step();
        exp = {2'b10, 3'd3, 5'b11000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL regrant_done: got %b exp %b", obs, exp); end
        coreReq = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_simultaneous();
        test_back_to_back();
        test_addr_err();
        test_z_data();
        test_dropped_req();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
